// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard comparator between EX and ID.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import hazard_pkg::*;
(
    input  logic             i_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    output logic             o_lu
);

    assign o_lu = i_mem_read && (i_ex_rt != REG_ZERO) &&
                  ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Hazard unit: multi-cycle load-use stall, branch/jump flush and
//               data-memory freeze. HAZARD_PERF_EN adds performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             jump_id,
    input  logic             branch_taken_ex,
    input  logic             dmem_busy,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flush_count,
    output logic [CNT_W-1:0] perf_freeze_cycles
`endif
);

    localparam logic [2:0] c_lu_reload = 3'(LOAD_USE_CYCLES - 1);

    hz_state_t  r_state, r_ret_state;
    hz_state_t  w_next_state, w_next_ret, w_eval_state;
    logic [2:0] r_cnt, w_next_cnt;
    logic       w_lu;

    load_use_detect u_load_use_detect (
        .i_mem_read   (id_ex_mem_read),
        .i_ex_rt      (id_ex_rt),
        .i_id_rs      (if_id_rs),
        .i_id_rt      (if_id_rt),
        .i_id_uses_rt (if_id_uses_rt),
        .o_lu         (w_lu)
    );

    always_comb begin
        // Leaving MEM_WAIT behaves exactly like the interrupted state this cycle.
        w_eval_state = (r_state == MEM_WAIT && !dmem_busy) ? r_ret_state : r_state;
        w_next_state = w_eval_state;
        w_next_ret   = r_ret_state;
        w_next_cnt   = r_cnt;
        stall        = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_freeze  = 1'b0;

        if (!reset) begin
            case (w_eval_state)
                RUN: begin
                    if (dmem_busy) begin
                        pipe_freeze  = 1'b1;
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        w_next_state = MEM_WAIT;
                        w_next_ret   = RUN;
                    end else if (branch_taken_ex) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (w_lu) begin
                        stall       = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        if (LOAD_USE_CYCLES > 1) begin
                            w_next_state = LU_STALL;
                            w_next_cnt   = c_lu_reload;
                        end
                    end else if (jump_id) begin
                        if_id_flush = 1'b1;
                    end
                end
                LU_STALL: begin
                    if (dmem_busy) begin
                        pipe_freeze  = 1'b1;
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        w_next_state = MEM_WAIT;
                        w_next_ret   = LU_STALL;
                    end else if (branch_taken_ex) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        w_next_cnt   = 3'd0;
                        w_next_state = RUN;
                    end else begin
                        stall       = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        if (r_cnt <= 3'd1) begin
                            w_next_cnt   = 3'd0;
                            w_next_state = RUN;
                        end else begin
                            w_next_cnt = r_cnt - 3'd1;
                        end
                    end
                end
                MEM_WAIT: begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end
                default: begin
                    w_next_state = RUN;
                    w_next_cnt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
            r_cnt       <= 3'd0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_cnt       <= w_next_cnt;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles  <= '0;
            perf_flush_count   <= '0;
            perf_freeze_cycles <= '0;
        end else begin
            if (stall && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if ((if_id_flush || id_ex_flush) && perf_flush_count != '1)
                perf_flush_count <= perf_flush_count + 1'b1;
            if (pipe_freeze && perf_freeze_cycles != '1)
                perf_freeze_cycles <= perf_freeze_cycles + 1'b1;
        end
    end
`else
    // Counter width only matters when the counters are built.
    generate
        if (CNT_W < 1) begin : g_cnt_w_unused
        end
    endgenerate
`endif

endmodule
`default_nettype wire
